spi_csr_fifo: RTL and testbench
===============================

# spi_csr_fifo

Parametrised APB-side register block for the SPI master. It succeeds the single-word register block: TX and RX FIFOs replace the single data registers, the slave-select count is configurable, the start control is a self-clearing pulse, and a write-1-to-clear interrupt block drives a level `irq`. It sits between the APB slave bridge (address/enable/ack interface) and the SPI shift engine (FIFO pop/push, config, busy).

## Interface
- `WORD_W`, 32: SPI word width, 8..32; FIFO data width.
- `NUM_SS`, 4: slave-select count, 1..8.
- `FIFO_DEPTH`, 8: entries per FIFO; power of two, 2..64.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low; every flop cleared in the cycle `reset`=0 is sampled.
- `waddr`, `raddr` in 32: byte addresses.
- `wdata` in 32: write data.
- `wr_en`, `rd_en` in 1: one-cycle access strobes.
- `rdata` out 32: registered read data.
- `rack`, `wack` out 1: registered acks.
- `raddrerr`, `waddrerr` out 1: combinational decode errors.
- `tx_data` out WORD_W: TX FIFO head.
- `tx_empty` out 1: TX FIFO empty.
- `tx_pop` in 1: engine consumes head; ignored when empty.
- `rx_data` in WORD_W: received word.
- `rx_push` in 1: engine writes `rx_data`.
- `busy` in 1: engine active.
- `ctrl_cpol`, `ctrl_cpha`, `ctrl_order`, `ctrl_rd` out 1: config bits.
- `ctrl_slave_en` out NUM_SS: slave-select enables.
- `ctrl_scks` out 2: SCK divider select.
- `start_op` out 1: one-cycle start pulse.
- `irq` out 1: registered interrupt.

## Operation
- Map, byte offsets:
  - 0x00 TXDATA: W pushes `wdata[WORD_W-1:0]`; R returns 0.
  - 0x04 RXDATA: R pops; W is an error.
  - 0x08 CFG, RW:
    - [0] cpol, [1] cpha, [2] order.
    - [NUM_SS+2:3] slave_en.
    - [NUM_SS+3] rd.
    - [NUM_SS+5:NUM_SS+4] scks.
    - Other bits write-ignored, read 0.
  - 0x0C CTRL, W-only fields, reads 0:
    - [0] start.
    - [1] tx_flush.
    - [2] rx_flush.
  - 0x10 STATUS, RO, W is an error:
    - [0] busy, [1] tx_full, [2] tx_empty, [3] rx_full, [4] rx_empty.
    - [14:8] tx_level, [22:16] rx_level.
  - 0x14 INT_STAT, R / W1C:
    - [0] done (busy falling edge).
    - [1] tx_ovf (push while full).
    - [2] rx_ovf (engine push while full).
    - [3] rx_unf (RXDATA read while empty).
  - 0x18 INT_EN, RW [3:0].
- `raddrerr`/`waddrerr` assert for unmapped addresses and for the wrong-direction accesses above. An erroneous access changes no state and produces no ack.
- Full TX FIFO: the push is dropped, tx_ovf is set, `wack` is still 1.
- Full RX FIFO: the engine push is dropped and rx_ovf is set.
- Empty RX read: `rdata`=0, no pop, rx_unf is set.
- Simultaneous push and pop on a full or empty FIFO: both take effect (bypass not required; level unchanged when full).
- Flush and push in the same cycle: flush wins, so the FIFO ends empty.
- Hardware set and W1C on the same INT_STAT bit in the same cycle: set wins.
- `start_op` asserts for one cycle after a CTRL write with [0]=1, whether or not the TX FIFO holds data.
- `irq` = registered |(INT_STAT & INT_EN).

## Timing
- Reset values: every output 0 except `tx_empty`=1; both FIFOs empty; CFG, INT_STAT and INT_EN are 0.
- Access at cycle N → `rack`/`wack`/`rdata` valid at N+1 for exactly one cycle. `rdata` holds its value until the next read.
- TX push at N → `tx_empty`=0 and `tx_data` valid at N+1.
- `tx_pop` at N → the next head appears at N+1.
- RX push at N → readable at N+1.
- RXDATA read at N → data at N+1; level decrements at N+1.
- Config write at N → `ctrl_*` updated at N+1.
- CTRL start at N → `start_op`=1 at N+1.
- busy 1→0 sampled at N → INT_STAT.done=1 at N+1 → `irq` at N+2 if enabled.
- Reset mid-operation clears everything within the cycle, including FIFO contents and pending pulses.

## Structure
- Package `spi_csr_pkg`: address localparams, INT_STAT bit indices, STATUS field offsets, CFG offsets as functions of NUM_SS.
- Sub-module `spi_sync_fifo` (params WIDTH, DEPTH):
  - Ports: push, pop, flush, dout, full, empty, level.
  - Pointers are $clog2(DEPTH)+1 bits so full and empty are distinguished on wrap.
  - Instantiated twice, once for TX and once for RX.

## Test plan
- Reset, then read every address → all 0 except STATUS=0x0000_0014 (tx_empty and rx_empty set).
- Push 9 words 0xA0..0xA8 with FIFO_DEPTH=8 → STATUS.tx_level=8, INT_STAT=0x2, then 8 `tx_pop`s return 0xA0..0xA7 in order.
- Engine pushes 0x11, 0x22; read RXDATA three times → rdata 0x11, 0x22, 0; INT_STAT.rx_unf=1; INT_EN=0x8 → `irq`=1; write INT_STAT=0x8 → `irq`=0 two cycles later.
- CFG write 0x3FF with NUM_SS=4 → cpol=cpha=order=1, slave_en=0xF, rd=1, scks=3; CTRL=0x1 → single-cycle `start_op`; busy 1→0 → done set.
- Same-cycle cases:
  - W1C done while busy falls → done stays 1.
  - TX flush with bus push → tx_empty=1.
  - Full RX FIFO with push and pop → level stays 8.
- Reset asserted with both FIFOs half full and irq high → next cycle all outputs at reset values.

Source files
------------

// File: rtl/spi_csr_pkg.sv
// Shared register map, interrupt bit positions and field offsets for the
// SPI master CSR block with TX/RX FIFOs.
package spi_csr_pkg;

    localparam logic [31:0] ADDR_TXDATA   = 32'h00;
    localparam logic [31:0] ADDR_RXDATA   = 32'h04;
    localparam logic [31:0] ADDR_CFG      = 32'h08;
    localparam logic [31:0] ADDR_CTRL     = 32'h0C;
    localparam logic [31:0] ADDR_STATUS   = 32'h10;
    localparam logic [31:0] ADDR_INT_STAT = 32'h14;
    localparam logic [31:0] ADDR_INT_EN   = 32'h18;

    localparam int INT_DONE   = 0;
    localparam int INT_TX_OVF = 1;
    localparam int INT_RX_OVF = 2;
    localparam int INT_RX_UNF = 3;

    localparam int ST_BUSY     = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_RX_EMPTY = 4;
    localparam int ST_TX_LEVEL = 8;
    localparam int ST_RX_LEVEL = 16;

    localparam int CFG_CPOL  = 0;
    localparam int CFG_CPHA  = 1;
    localparam int CFG_ORDER = 2;
    localparam int CFG_SS    = 3;

    function automatic int cfg_rd_bit(input int num_ss);
        return num_ss + 3;
    endfunction

    function automatic int cfg_scks_lo(input int num_ss);
        return num_ss + 4;
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with extra pointer MSB to tell full from empty on wrap.
// Flush beats push; pop on empty is ignored; push on full is dropped unless popped.
module spi_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level   = wptr - rptr;
    assign dout    = mem[rptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= din;
                wptr <= wptr + ONE;
            end
            if (do_pop) begin
                rptr <= rptr + ONE;
            end
        end
    end

endmodule

// File: rtl/spi_csr_fifo.sv
// APB-side CSR block for the SPI master: TX/RX FIFOs, config, start pulse,
// W1C interrupt status and a registered level irq.
module spi_csr_fifo
    import spi_csr_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int NUM_SS     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       waddr,
    input  logic [31:0]       raddr,
    input  logic [31:0]       wdata,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [31:0]       rdata,
    output logic              rack,
    output logic              wack,
    output logic              raddrerr,
    output logic              waddrerr,
    output logic [WORD_W-1:0] tx_data,
    output logic              tx_empty,
    input  logic              tx_pop,
    input  logic [WORD_W-1:0] rx_data,
    input  logic              rx_push,
    input  logic              busy,
    output logic              ctrl_cpol,
    output logic              ctrl_cpha,
    output logic              ctrl_order,
    output logic              ctrl_rd,
    output logic [NUM_SS-1:0] ctrl_slave_en,
    output logic [1:0]        ctrl_scks,
    output logic              start_op,
    output logic              irq
);

    localparam int LW       = $clog2(FIFO_DEPTH) + 1;
    localparam int CFG_RD   = cfg_rd_bit(NUM_SS);
    localparam int CFG_SCKS = cfg_scks_lo(NUM_SS);
    localparam int CFG_W    = CFG_SCKS + 2;

    logic              rd_ok, wr_ok;
    logic              tx_push, cfg_wr, ctrl_wr, ist_wr, ien_wr;
    logic              rx_rd, rx_pop, tx_flush, rx_flush;
    logic              tx_full, rx_full, rx_empty;
    logic [LW-1:0]     tx_level, rx_level;
    logic [WORD_W-1:0] rx_dout;
    logic [CFG_W-1:0]  cfg_q;
    logic [3:0]        int_stat, int_en, int_set, int_clr;
    logic              busy_q;
    logic [31:0]       status, rd_word;

    assign rd_ok = rd_en && (raddr inside {ADDR_TXDATA, ADDR_RXDATA, ADDR_CFG,
        ADDR_CTRL, ADDR_STATUS, ADDR_INT_STAT, ADDR_INT_EN});
    assign wr_ok = wr_en && (waddr inside {ADDR_TXDATA, ADDR_CFG, ADDR_CTRL,
        ADDR_INT_STAT, ADDR_INT_EN});
    assign raddrerr = rd_en && !rd_ok;
    assign waddrerr = wr_en && !wr_ok;

    assign tx_push  = wr_ok && (waddr == ADDR_TXDATA);
    assign cfg_wr   = wr_ok && (waddr == ADDR_CFG);
    assign ctrl_wr  = wr_ok && (waddr == ADDR_CTRL);
    assign ist_wr   = wr_ok && (waddr == ADDR_INT_STAT);
    assign ien_wr   = wr_ok && (waddr == ADDR_INT_EN);
    assign rx_rd    = rd_ok && (raddr == ADDR_RXDATA);
    assign rx_pop   = rx_rd && !rx_empty;
    assign tx_flush = ctrl_wr && wdata[1];
    assign rx_flush = ctrl_wr && wdata[2];

    spi_sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop),
        .flush(tx_flush), .din(wdata[WORD_W-1:0]), .dout(tx_data),
        .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    spi_sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop),
        .flush(rx_flush), .din(rx_data), .dout(rx_dout),
        .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

    assign ctrl_cpol     = cfg_q[CFG_CPOL];
    assign ctrl_cpha     = cfg_q[CFG_CPHA];
    assign ctrl_order    = cfg_q[CFG_ORDER];
    assign ctrl_slave_en = cfg_q[CFG_SS +: NUM_SS];
    assign ctrl_rd       = cfg_q[CFG_RD];
    assign ctrl_scks     = cfg_q[CFG_SCKS +: 2];

    // A push onto a full FIFO survives only if the same cycle pops.
    always_comb begin
        int_set             = '0;
        int_set[INT_DONE]   = busy_q && !busy;
        int_set[INT_TX_OVF] = tx_push && tx_full && !tx_pop;
        int_set[INT_RX_OVF] = rx_push && rx_full && !rx_pop;
        int_set[INT_RX_UNF] = rx_rd && rx_empty;
        int_clr             = ist_wr ? wdata[3:0] : 4'd0;
    end

    always_comb begin
        status                   = '0;
        status[ST_BUSY]          = busy;
        status[ST_TX_FULL]       = tx_full;
        status[ST_TX_EMPTY]      = tx_empty;
        status[ST_RX_FULL]       = rx_full;
        status[ST_RX_EMPTY]      = rx_empty;
        status[ST_TX_LEVEL +: 7] = 7'(tx_level);
        status[ST_RX_LEVEL +: 7] = 7'(rx_level);
    end

    always_comb begin
        rd_word = '0;
        case (raddr)
            ADDR_RXDATA:   rd_word[WORD_W-1:0] = rx_empty ? '0 : rx_dout;
            ADDR_CFG:      rd_word[CFG_W-1:0]  = cfg_q;
            ADDR_STATUS:   rd_word             = status;
            ADDR_INT_STAT: rd_word[3:0]        = int_stat;
            ADDR_INT_EN:   rd_word[3:0]        = int_en;
            default:       rd_word             = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata    <= '0;
            rack     <= 1'b0;
            wack     <= 1'b0;
            start_op <= 1'b0;
            irq      <= 1'b0;
            busy_q   <= 1'b0;
            cfg_q    <= '0;
            int_stat <= '0;
            int_en   <= '0;
        end else begin
            rack     <= rd_ok;
            wack     <= wr_ok;
            start_op <= ctrl_wr && wdata[0];
            busy_q   <= busy;
            if (rd_ok) begin
                rdata <= rd_word;
            end
            if (cfg_wr) begin
                cfg_q <= wdata[CFG_W-1:0];
            end
            if (ien_wr) begin
                int_en <= wdata[3:0];
            end
            int_stat <= (int_stat & ~int_clr) | int_set;
            irq      <= |(int_stat & int_en);
        end
    end

endmodule

// File: tb/tb_spi_csr_fifo.sv
// Directed bench for spi_csr_fifo at WORD_W=32, NUM_SS=4, FIFO_DEPTH=8.
module tb_spi_csr_fifo;
    import spi_csr_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] waddr, raddr, wdata;
    logic        wr_en, rd_en;
    logic [31:0] rdata;
    logic        rack, wack, raddrerr, waddrerr;
    logic [31:0] tx_data;
    logic        tx_empty, tx_pop;
    logic [31:0] rx_data;
    logic        rx_push, busy;
    logic        ctrl_cpol, ctrl_cpha, ctrl_order, ctrl_rd;
    logic [3:0]  ctrl_slave_en;
    logic [1:0]  ctrl_scks;
    logic        start_op, irq;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    spi_csr_fifo #(.WORD_W(32), .NUM_SS(4), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .waddr(waddr), .raddr(raddr),
        .wdata(wdata), .wr_en(wr_en), .rd_en(rd_en), .rdata(rdata),
        .rack(rack), .wack(wack), .raddrerr(raddrerr),
        .waddrerr(waddrerr), .tx_data(tx_data), .tx_empty(tx_empty),
        .tx_pop(tx_pop), .rx_data(rx_data), .rx_push(rx_push),
        .busy(busy), .ctrl_cpol(ctrl_cpol), .ctrl_cpha(ctrl_cpha),
        .ctrl_order(ctrl_order), .ctrl_rd(ctrl_rd),
        .ctrl_slave_en(ctrl_slave_en), .ctrl_scks(ctrl_scks),
        .start_op(start_op), .irq(irq)
    );

    // {rack,wack,tx_empty,cpol,cpha,order,rd,slave_en,scks,start_op,irq,raddrerr,waddrerr}
    function automatic logic [31:0] flags();
        return 32'({rack, wack, tx_empty, ctrl_cpol, ctrl_cpha, ctrl_order,
            ctrl_rd, ctrl_slave_en, ctrl_scks, start_op, irq, raddrerr,
            waddrerr});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        waddr = a;
        wdata = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [31:0] a,
                         input logic [31:0] exp);
        @(negedge clk);
        raddr = a;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk(tag, rdata, exp);
    endtask

    task automatic epush(input logic [31:0] d);
        @(negedge clk);
        rx_data = d;
        rx_push = 1'b1;
        @(negedge clk);
        rx_push = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        waddr = '0;
        raddr = '0;
        wdata = '0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        tx_pop = 1'b0;
        rx_data = '0;
        rx_push = 1'b0;
        busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_flags", flags(), 32'h0000_4000);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_txdata", tx_data, 32'h0);
        reset = 1'b1;

        rdchk("rd_txdata", ADDR_TXDATA, 32'h0);
        chk("rack_on", 32'(rack), 32'h1);
        @(negedge clk);
        chk("rack_off", 32'(rack), 32'h0);
        rdchk("rd_cfg", ADDR_CFG, 32'h0);
        rdchk("rd_ctrl", ADDR_CTRL, 32'h0);
        rdchk("rd_status", ADDR_STATUS, 32'h0000_0014);
        rdchk("rd_intstat", ADDR_INT_STAT, 32'h0);
        rdchk("rd_inten", ADDR_INT_EN, 32'h0);
        rdchk("rd_rxdata", ADDR_RXDATA, 32'h0);
        rdchk("unf_rst", ADDR_INT_STAT, 32'h8);
        wr(ADDR_INT_STAT, 32'h8);
        rdchk("unf_clr", ADDR_INT_STAT, 32'h0);

        @(negedge clk);
        raddr = 32'h1C;
        rd_en = 1'b1;
        #1 chk("raddrerr", 32'(raddrerr), 32'h1);
        @(negedge clk);
        rd_en = 1'b0;
        chk("rack_err", 32'(rack), 32'h0);
        @(negedge clk);
        waddr = ADDR_RXDATA;
        wdata = 32'hFFFF_FFFF;
        wr_en = 1'b1;
        #1 chk("waddrerr_rx", 32'(waddrerr), 32'h1);
        @(negedge clk);
        waddr = ADDR_STATUS;
        #1 chk("waddrerr_st", 32'(waddrerr), 32'h1);
        @(negedge clk);
        wr_en = 1'b0;
        chk("wack_err", 32'(wack), 32'h0);

        for (int i = 0; i < 9; i++) begin
            wr(ADDR_TXDATA, 32'(32'hA0 + i));
            if (i == 0) begin
                chk("tx_nempty", 32'(tx_empty), 32'h0);
                chk("tx_head", tx_data, 32'hA0);
            end
        end
        chk("wack_ovf", 32'(wack), 32'h1);
        rdchk("st_txfull", ADDR_STATUS, 32'h0000_0812);
        rdchk("int_txovf", ADDR_INT_STAT, 32'h2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("tx_order", tx_data, 32'(32'hA0 + i));
            tx_pop = 1'b1;
            @(negedge clk);
            tx_pop = 1'b0;
        end
        chk("tx_drained", 32'(tx_empty), 32'h1);
        @(negedge clk);
        tx_pop = 1'b1;
        @(negedge clk);
        tx_pop = 1'b0;
        rdchk("pop_empty", ADDR_STATUS, 32'h0000_0014);
        wr(ADDR_INT_STAT, 32'h2);
        rdchk("txovf_clr", ADDR_INT_STAT, 32'h0);

        epush(32'h11);
        epush(32'h22);
        rdchk("rx_0", ADDR_RXDATA, 32'h11);
        rdchk("rx_1", ADDR_RXDATA, 32'h22);
        rdchk("rx_unf", ADDR_RXDATA, 32'h0);
        rdchk("int_unf", ADDR_INT_STAT, 32'h8);
        wr(ADDR_INT_EN, 32'h8);
        chk("irq_lat", 32'(irq), 32'h0);
        @(negedge clk);
        chk("irq_on", 32'(irq), 32'h1);
        wr(ADDR_INT_STAT, 32'h8);
        chk("irq_hold", 32'(irq), 32'h1);
        @(negedge clk);
        chk("irq_off", 32'(irq), 32'h0);

        wr(ADDR_CFG, 32'h3FF);
        chk("cfg_out", flags(), 32'h0000_FFF0);
        rdchk("cfg_rd", ADDR_CFG, 32'h3FF);
        wr(ADDR_CFG, 32'hFFFF_FFFF);
        rdchk("cfg_mask", ADDR_CFG, 32'h3FF);
        wr(ADDR_CFG, 32'hA5);
        chk("cfg_a5", 32'({ctrl_cpol, ctrl_cpha, ctrl_order, ctrl_slave_en,
            ctrl_rd, ctrl_scks}), 32'b101_0100_1_00);
        rdchk("cfg_a5_rd", ADDR_CFG, 32'hA5);

        wr(ADDR_CTRL, 32'h1);
        chk("start_on", 32'(start_op), 32'h1);
        @(negedge clk);
        chk("start_off", 32'(start_op), 32'h0);
        rdchk("ctrl_rd0", ADDR_CTRL, 32'h0);
        @(negedge clk);
        busy = 1'b1;
        @(negedge clk);
        busy = 1'b0;
        rdchk("done_set", ADDR_INT_STAT, 32'h1);
        chk("done_noirq", 32'(irq), 32'h0);

        @(negedge clk);
        busy = 1'b1;
        @(negedge clk);
        busy = 1'b0;
        waddr = ADDR_INT_STAT;
        wdata = 32'h1;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        rdchk("set_wins", ADDR_INT_STAT, 32'h1);
        wr(ADDR_INT_STAT, 32'hF);
        rdchk("int_clr_all", ADDR_INT_STAT, 32'h0);

        wr(ADDR_TXDATA, 32'h55);
        wr(ADDR_TXDATA, 32'h66);
        chk("tx_pre_fl", 32'(tx_empty), 32'h0);
        wr(ADDR_CTRL, 32'h2);
        chk("tx_flush", 32'(tx_empty), 32'h1);

        epush(32'h77);
        @(negedge clk);
        rx_data = 32'h88;
        rx_push = 1'b1;
        waddr = ADDR_CTRL;
        wdata = 32'h4;
        wr_en = 1'b1;
        @(negedge clk);
        rx_push = 1'b0;
        wr_en = 1'b0;
        rdchk("rx_flush", ADDR_STATUS, 32'h0000_0014);

        for (int i = 0; i < 8; i++) begin
            epush(32'(32'h30 + i));
        end
        rdchk("rx_full", ADDR_STATUS, 32'h0008_000C);
        @(negedge clk);
        rx_data = 32'h38;
        rx_push = 1'b1;
        raddr = ADDR_RXDATA;
        rd_en = 1'b1;
        @(negedge clk);
        rx_push = 1'b0;
        rd_en = 1'b0;
        chk("pp_rdata", rdata, 32'h30);
        rdchk("pp_level", ADDR_STATUS, 32'h0008_000C);
        rdchk("pp_noovf", ADDR_INT_STAT, 32'h0);
        epush(32'h39);
        rdchk("rx_ovf", ADDR_INT_STAT, 32'h4);
        for (int i = 1; i < 5; i++) begin
            rdchk("rx_drain", ADDR_RXDATA, 32'(32'h30 + i));
        end
        for (int i = 0; i < 4; i++) begin
            wr(ADDR_TXDATA, 32'(32'hC0 + i));
        end
        wr(ADDR_INT_EN, 32'h4);
        @(negedge clk);
        chk("irq_ovf", 32'(irq), 32'h1);
        rdchk("half_full", ADDR_STATUS, 32'h0004_0400);

        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_flags", flags(), 32'h0000_4000);
        chk("mid_rst_rdata", rdata, 32'h0);
        chk("mid_rst_txd", tx_data, 32'h0);
        reset = 1'b1;
        rdchk("post_status", ADDR_STATUS, 32'h0000_0014);
        rdchk("post_intst", ADDR_INT_STAT, 32'h0);
        rdchk("post_inten", ADDR_INT_EN, 32'h0);
        rdchk("post_cfg", ADDR_CFG, 32'h0);
        rdchk("post_rx", ADDR_RXDATA, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
